// File: rtl/piso_tx_scheduler.sv
// Round-robin arbiter in front of a shared PISO shift path: grants one requester
// per frame, loads its word and shifts it out LSB-first with first/last strobes.
module piso_tx_scheduler #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int GW    = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  ser_first,
    output logic                  ser_last,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                       state, state_d;
    logic [WIDTH-1:0]             shreg, shreg_d;
    logic [CW-1:0]                cnt, cnt_d;
    logic [GW-1:0]                rr_ptr, rr_ptr_d, gid_d, win;
    logic                         win_found, open, accept;
    logic [NREQ-1:0][WIDTH-1:0]   words;

    assign words = req_data;

    // Scan from the highest offset down so the nearest valid requester after
    // rr_ptr is the last one written.
    always_comb begin
        int idx;
        idx       = 0;
        win       = '0;
        win_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                win       = GW'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign open      = (state == IDLE) || (cnt == '0);
    assign accept    = open && win_found && !RST;
    assign req_ready = accept ? (NREQ'(1) << win) : '0;

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        cnt_d    = cnt;
        rr_ptr_d = rr_ptr;
        gid_d    = grant_id;
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = words[win];
            cnt_d    = CW'(WIDTH - 1);
            gid_d    = win;
            rr_ptr_d = (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                shreg_d = shreg >> 1;
                cnt_d   = cnt - CW'(1);
            end else begin
                state_d = IDLE;
                shreg_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            cnt      <= cnt_d;
            rr_ptr   <= rr_ptr_d;
            grant_id <= gid_d;
        end
    end

    assign busy      = (state == SHIFT);
    assign ser_valid = busy;
    assign ser_out   = shreg[0];
    assign ser_first = busy && (cnt == CW'(WIDTH - 1));
    assign ser_last  = busy && (cnt == '0);

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler: frame-position reference model compared
// every cycle, plus hand-computed literal expectations per scenario.
module tb_piso_tx_scheduler;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  ser_out, ser_valid, ser_first, ser_last, busy;
    logic [1:0]            grant_id;

    int checks = 0;
    int errors = 0;

    piso_tx_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_first(ser_first), .ser_last(ser_last), .grant_id(grant_id),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position (-1 idle, else index of bit on the line).
    int         m_pos = -1;
    int         m_id  = 0;
    int         m_ptr = 0;
    logic [7:0] m_word = '0;

    function automatic int m_winner();
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic bit m_open();
        return (m_pos < 0) || (m_pos == WIDTH - 1);
    endfunction

    function automatic logic [31:0] m_ready();
        if (RST || !m_open() || m_winner() < 0) return 0;
        return 32'd1 << m_winner();
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pos  <= -1;
            m_id   <= 0;
            m_ptr  <= 0;
            m_word <= '0;
        end else if (m_open() && m_winner() >= 0) begin
            m_word <= req_data[m_winner()*WIDTH +: WIDTH];
            m_pos  <= 0;
            m_id   <= m_winner();
            m_ptr  <= (m_winner() + 1) % NREQ;
        end else if (m_pos >= 0 && m_pos < WIDTH - 1) begin
            m_pos <= m_pos + 1;
        end else begin
            m_pos <= -1;
        end
    end

    always @(negedge CLK) begin
        chk("cmp_ready", req_ready, m_ready());
        chk("cmp_ser_valid", ser_valid, (m_pos >= 0));
        chk("cmp_busy", busy, (m_pos >= 0));
        chk("cmp_ser_out", ser_out, (m_pos >= 0) ? m_word[m_pos] : 1'b0);
        chk("cmp_ser_first", ser_first, (m_pos == 0));
        chk("cmp_ser_last", ser_last, (m_pos == WIDTH - 1));
        chk("cmp_grant_id", grant_id, m_id);
    end

    int exp_a5[8]     = '{1, 0, 1, 0, 0, 1, 0, 1};
    int ready_last[4] = '{2, 4, 8, 1};

    initial begin
        RST = 1'b1;
        req_valid = '0;
        req_data  = '0;

        // Reset state, mid-cycle reset pulse, single request of 8'hA5
        repeat (2) @(negedge CLK);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_id, 0);
        #1 RST = 1'b0;
        #1 RST = 1'b1;
        #1 RST = 1'b0;
        req_data[7:0] = 8'hA5;
        @(negedge CLK);
        #1 req_valid = 4'b0001;
        #1 chk("t1_ready", req_ready, 4'b0001);
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            chk("t1_ser_out", ser_out, exp_a5[j]);
            chk("t1_first", ser_first, (j == 0));
            chk("t1_last", ser_last, (j == 7));
            chk("t1_grant", grant_id, 0);
            if (j == 0) #1 req_valid = 4'b0000;
        end
        @(negedge CLK);
        chk("t1_busy_after", busy, 0);
        chk("t1_ser_out_idle", ser_out, 0);

        // Round-robin fairness from a fresh pointer, gapless frames
        #1 RST = 1'b1;
        #1 RST = 1'b0;
        req_data = {8'h08, 8'h04, 8'h02, 8'h01};
        #1 req_valid = 4'b1111;
        #1 chk("t2_ready0", req_ready, 4'b0001);
        for (int n = 0; n < 32; n++) begin
            @(negedge CLK);
            chk("t2_ser_valid", ser_valid, 1);
            if (n % 8 == 0) chk("t2_grant", grant_id, n / 8);
            if (n % 8 == 7) chk("t2_ready_last", req_ready, ready_last[n / 8]);
            else            chk("t2_ready_mid", req_ready, 0);
        end
        #1 req_valid = 4'b0000;
        repeat (10) @(negedge CLK);

        // Priority pointer persists across idle cycles
        #1 req_valid = 4'b0100;
        @(negedge CLK);
        chk("t3_grant2", grant_id, 2);
        #1 req_valid = 4'b0000;
        repeat (12) @(negedge CLK);
        chk("t3_idle", busy, 0);
        #1 req_valid = 4'b1001;
        #1 chk("t3_ready3", req_ready, 4'b1000);
        @(negedge CLK);
        chk("t3_grant3", grant_id, 3);
        #1 req_valid = 4'b0001;
        repeat (7) @(negedge CLK);
        chk("t3_ready0", req_ready, 4'b0001);
        @(negedge CLK);
        chk("t3_grant0", grant_id, 0);
        chk("t3_first0", ser_first, 1);
        #1 req_valid = 4'b0000;
        repeat (9) @(negedge CLK);

        // Gap: three idle cycles between frames from requester 1
        #1 req_valid = 4'b0010;
        @(negedge CLK);
        chk("t4_grant1", grant_id, 1);
        #1 req_valid = 4'b0000;
        repeat (7) @(negedge CLK);
        chk("t4_last", ser_last, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t4_gap_busy", busy, 0);
            chk("t4_gap_ser_out", ser_out, 0);
        end
        #1 req_valid = 4'b0010;
        #1 chk("t4_ready", req_ready, 4'b0010);
        @(negedge CLK);
        chk("t4_busy_again", busy, 1);
        chk("t4_first_again", ser_first, 1);
        #1 req_valid = 4'b0000;
        repeat (9) @(negedge CLK);

        // Asynchronous reset at bit 4 of a frame
        req_data[7:0] = 8'hFF;
        #1 req_valid = 4'b0001;
        @(negedge CLK);
        #1 req_valid = 4'b0000;
        repeat (4) @(negedge CLK);
        chk("t5_mid_frame", ser_valid, 1);
        #1 RST = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("t5_rst_ser_out", ser_out, 0);
        chk("t5_rst_ser_valid", ser_valid, 0);
        chk("t5_rst_first", ser_first, 0);
        chk("t5_rst_last", ser_last, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_grant", grant_id, 0);
        chk("t5_rst_ready", req_ready, 0);
        @(negedge CLK);
        chk("t5_rst_ready_hold", req_ready, 0);
        #1 RST = 1'b0;
        #1 chk("t5_ready1", req_ready, 4'b0010);
        @(negedge CLK);
        chk("t5_grant1", grant_id, 1);
        #1 req_valid = 4'b1000;
        repeat (7) @(negedge CLK);
        chk("t5_ready3", req_ready, 4'b1000);
        @(negedge CLK);
        chk("t5_grant3", grant_id, 3);
        #1 req_valid = 4'b0000;
        repeat (9) @(negedge CLK);

        // No grant mid-frame: requester 3 waits for requester 0's ser_last
        req_data[7:0] = 8'h3C;
        #1 req_valid = 4'b0001;
        @(negedge CLK);
        #1 req_valid = 4'b0000;
        repeat (2) @(negedge CLK);
        #1 req_valid = 4'b1000;
        #1 chk("t6_ready_bit2", req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("t6_ready_mid", req_ready, 0);
        end
        @(negedge CLK);
        chk("t6_last", ser_last, 1);
        chk("t6_ready_last", req_ready, 4'b1000);
        @(negedge CLK);
        chk("t6_grant3", grant_id, 3);
        chk("t6_first", ser_first, 1);
        #1 req_valid = 4'b0000;
        repeat (10) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_tx_scheduler.md
# piso_tx_scheduler

Round-robin scheduler that shares one parallel-in/serial-out shift path between NREQ parallel requesters. It grants one requester per frame via a valid/ready handshake and loads the winner's WIDTH-bit word into the shift register. It then shifts the word out LSB-first, one bit per clock, with framing strobes. It sits in front of the serial link as the sequencing and arbitration layer for the PISO datapath.

## Interface
- WIDTH, 8, bits per frame (≥2)
- NREQ, 4, number of requesters (≥2)
- GW, $clog2(NREQ), width of grant index (derived localparam)

- CLK  input  1  single clock, all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  bit i: requester i holds a word
- req_data  input  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a frame bit this cycle
- ser_first  output  1  first bit (bit 0) of a frame
- ser_last  output  1  last bit (bit WIDTH-1) of a frame
- grant_id  output  GW  index of requester whose frame is on ser_out
- busy  output  1  high while state is SHIFT

## Operation
- States: IDLE, SHIFT. Registers: shreg[WIDTH-1:0], cnt (counts remaining bits), rr_ptr[GW-1:0], grant_id, state.
- Accept window: `open` = (state==IDLE) | (state==SHIFT & cnt==0).
- Arbitration: when `open`, the winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … with wrap modulo NREQ. req_ready is one-hot on the winner and zero otherwise. It is combinational from req_valid and registers, and all-zero when no valid or not `open`.
- Requesters must hold req_valid and req_data stable until accepted. Dropping valid before grant is tolerated, and arbitration simply re-evaluates.
- On accept (edge with a winner at `open`):
  - shreg <= winner's word
  - cnt <= WIDTH-1
  - grant_id <= winner
  - rr_ptr <= (winner+1) mod NREQ
  - state <= SHIFT
- In SHIFT with cnt≠0: shreg <= shreg >> 1 (zero fill), cnt <= cnt-1.
- In SHIFT with cnt==0 and no winner: state <= IDLE, shreg <= 0.
- Outputs, derived from registers only:
  - ser_out = shreg[0]
  - ser_valid = busy = (state==SHIFT)
  - ser_first = SHIFT & cnt==WIDTH-1
  - ser_last = SHIFT & cnt==0
- In IDLE, ser_out=0 and grant_id holds its last value.
- Reset values: state IDLE, shreg 0, cnt 0, rr_ptr 0, grant_id 0. Consequently req_ready=0 unless valid present, and ser_out, ser_valid, ser_first, ser_last, busy are all 0.
- Reset mid-frame: frame is abandoned immediately (asynchronously). No partial completion and no grant are issued during reset. Arbitration restarts from requester 0.
- rr_ptr changes only on accept. Idle cycles do not rotate priority.

## Timing
- Accept on edge k → bit 0 on ser_out in cycle k+1 (ser_first=1). Bit j appears in cycle k+1+j, and bit WIDTH-1 in cycle k+WIDTH (ser_last=1).
- Latency from req_valid rising in IDLE to first serial bit: 1 cycle. req_ready is high in the same cycle as valid.
- Back-to-back: a request pending during the ser_last cycle is accepted at the end of that cycle. Its bit 0 follows in the next cycle with no gap, giving a sustained throughput of one frame per WIDTH cycles.
- Without a pending request, busy falls the cycle after ser_last.
- No request can be accepted mid-frame (cnt≠0). req_ready stays all-zero during that time.
- WIDTH=1 is unsupported. ser_first and ser_last are never both high.

## Test plan
- Reset then single request: RST pulse mid-cycle, then req_valid=4'b0001, word0=8'hA5. Required: req_ready=4'b0001 for 1 cycle, then ser_out=1,0,1,0,0,1,0,1 over 8 cycles, ser_first on cycle 1, ser_last on cycle 8, grant_id=0, busy then 0.
- Round-robin fairness: all four valid continuously with words 8'h01, 8'h02, 8'h04, 8'h08. Required: grants 0,1,2,3,0,… with frames gapless (ser_valid continuously high for 32 cycles) and each grant one cycle wide at ser_last.
- Priority pointer persistence: grant requester 2 alone, go idle 5 cycles, then raise valid on 0 and 3 together. Required: 3 is granted first (rr_ptr=3), then 0.
- Gap behaviour: requester 1 valid for one frame only, re-raised 3 cycles after ser_last. Required: busy low for exactly those idle cycles, ser_out=0 while idle, grant next cycle after valid.
- Reset mid-frame: assert RST asynchronously at bit 4 of a frame. Required: all outputs 0 immediately, rr_ptr=0. After release with req_valid=4'b1010, requester 1 wins first.
- No mid-frame grant: raise req_valid[3] at bit 2 of a frame from requester 0. Required: req_ready stays 0 until the ser_last cycle, then 4'b1000.
